// File: rtl/rf_wb_commit.sv
// rf_wb_commit: in-order dual-slot writeback commit FIFO for the register file.
// Optional WB_BYPASS_EN: pairs arriving at an empty, unheld FIFO skip the queue.
module rf_wb_commit #(
  parameter int data_width      = 32,
  parameter int bit_width_depth = 5,
  parameter int fifo_depth      = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_vld_alp,
  input  logic                       in_vld_bta,
  input  logic [bit_width_depth-1:0] in_addr_alp,
  input  logic [bit_width_depth-1:0] in_addr_bta,
  input  logic [data_width-1:0]      in_data_alp,
  input  logic [data_width-1:0]      in_data_bta,
  output logic                       in_ready,
  input  logic                       commit_hold,
  output logic                       wr_n_alp,
  output logic                       wr_n_bta,
  output logic [bit_width_depth-1:0] wr_addr_alp,
  output logic [bit_width_depth-1:0] wr_addr_bta,
  output logic [data_width-1:0]      data_in_alp,
  output logic [data_width-1:0]      data_in_bta,
  output logic [31:0]                pend_mask,
  output logic [$clog2(fifo_depth):0] count
);

  localparam int PW = $clog2(fifo_depth);
  localparam int CW = PW + 1;

  typedef logic [bit_width_depth-1:0] addr_t;
  typedef logic [data_width-1:0]      data_t;

  logic [fifo_depth-1:0] va_q;
  logic [fifo_depth-1:0] vb_q;
  addr_t aa_q [fifo_depth];
  addr_t ab_q [fifo_depth];
  data_t da_q [fifo_depth];
  data_t db_q [fifo_depth];

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic fa, fb;
  logic push, enq, pop, byp;

  // bta is the younger slot, so it wins a same-address collision
  assign fb = in_vld_bta & (|in_addr_bta);
  assign fa = in_vld_alp & (|in_addr_alp)
            & ~(fb & (in_addr_alp == in_addr_bta));

  assign in_ready = (cnt_q < CW'(fifo_depth));
  assign push     = (in_vld_alp | in_vld_bta) & in_ready;
  assign pop      = (cnt_q != '0) & ~commit_hold & ~reset;

`ifdef WB_BYPASS_EN
  assign byp = push & (fa | fb) & (cnt_q == '0)
             & ~commit_hold & ~reset;
`else
  assign byp = 1'b0;
`endif

  assign enq   = push & (fa | fb) & ~byp & ~reset;
  assign count = cnt_q;

  always_comb begin
    wp_d  = wp_q + PW'(enq);
    rp_d  = rp_q + PW'(pop);
    cnt_d = cnt_q;
    unique case ({enq, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // push and pop never share a slot: push needs room, pop needs data
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      va_q  <= '0;
      vb_q  <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      if (pop) begin
        va_q[rp_q] <= 1'b0;
        vb_q[rp_q] <= 1'b0;
      end
      if (enq) begin
        va_q[wp_q] <= fa;
        vb_q[wp_q] <= fb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      aa_q[wp_q] <= in_addr_alp;
      ab_q[wp_q] <= in_addr_bta;
      da_q[wp_q] <= in_data_alp;
      db_q[wp_q] <= in_data_bta;
    end
  end

  always_comb begin
    wr_n_alp    = 1'b1;
    wr_n_bta    = 1'b1;
    wr_addr_alp = '0;
    wr_addr_bta = '0;
    data_in_alp = '0;
    data_in_bta = '0;
    unique case (1'b1)
      byp: begin
        wr_n_alp    = ~fa;
        wr_n_bta    = ~fb;
        wr_addr_alp = in_addr_alp;
        wr_addr_bta = in_addr_bta;
        data_in_alp = in_data_alp;
        data_in_bta = in_data_bta;
      end
      pop: begin
        wr_n_alp    = ~va_q[rp_q];
        wr_n_bta    = ~vb_q[rp_q];
        wr_addr_alp = aa_q[rp_q];
        wr_addr_bta = ab_q[rp_q];
        data_in_alp = da_q[rp_q];
        data_in_bta = db_q[rp_q];
      end
      default: begin
        wr_n_alp = 1'b1;
        wr_n_bta = 1'b1;
      end
    endcase
  end

  // valid bits are cleared on pop, so only queued slots contribute
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < fifo_depth; i++) begin
      if (va_q[i]) pend_mask[aa_q[i]] = 1'b1;
      if (vb_q[i]) pend_mask[ab_q[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: doc/rf_wb_commit.md
# rf_wb_commit

Dual-issue writeback commit unit that sits between the two execution pipes (alp, bta) and the write side of the 32x32 register file. It accepts one result pair per cycle over a valid/ready handshake, buffers pairs in order in a small FIFO, resolves intra-pair and x0 hazards, and drives the register file's two active-low write ports. It also publishes a pending-write mask so issue logic can stall on registers that are queued but not yet written.

## Interface
- data_width, 32, result data width
- bit_width_depth, 5, register address width
- fifo_depth, 4, pair-FIFO entries; power of two, >= 2
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_vld_alp / in_vld_bta  in  1 each  slot valid from pipe alp / bta
- in_addr_alp / in_addr_bta  in  bit_width_depth each  destination register
- in_data_alp / in_data_bta  in  data_width each  result data
- in_ready  out  1  pair accepted this cycle when high and any in_vld high
- commit_hold  in  1  freeze commit; FIFO keeps filling
- wr_n_alp / wr_n_bta  out  1 each  register-file write enable, active low
- wr_addr_alp / wr_addr_bta  out  bit_width_depth each  write address
- data_in_alp / data_in_bta  out  data_width each  write data
- pend_mask  out  32  bit r set while a queued write targets register r
- count  out  clog2(fifo_depth)+1  queued pairs

## Operation
- Accept: push = (in_vld_alp | in_vld_bta) & in_ready; in_ready = (count < fifo_depth); a same-cycle pop does not raise in_ready.
- Slot filter at push: a slot with addr 0 is marked invalid; if addr_alp == addr_bta and both valid, alp slot is marked invalid (bta is younger). If both slots end invalid, the pair is accepted but not enqueued.
- Entry = {v_alp, addr_alp, data_alp, v_bta, addr_bta, data_bta}; circular buffer, rd/wr pointers wrap modulo fifo_depth.
- Commit: pop = (count > 0) & ~commit_hold. During pop, write outputs are driven from the head entry: wr_n_x = ~v_x, wr_addr_x/data_in_x = entry fields.
- When not popping: wr_n_alp = wr_n_bta = 1, wr_addr_* = 0, data_in_* = 0.
- Simultaneous push and pop: both occur; count unchanged.
- pend_mask: OR over all occupied entries of one-hot(addr) for each valid slot; bit 0 always 0. Combinational from FIFO state.
- Reset: pointers 0, count 0, all entry valid bits cleared; therefore wr_n_* = 1, wr_addr_*/data_in_* = 0, pend_mask = 0, in_ready = 1. Reset during pending commits discards them; no write is issued in the reset cycle.

## Timing
- Push in cycle N -> head write visible on write ports in cycle N+1 at earliest (1-cycle latency, FIFO empty, commit_hold low).
- Pair order preserved; one pair committed per cycle maximum; throughput 1 pair/cycle when not held.
- pend_mask bits set in cycle N+1 after push in N; cleared in cycle after the pop cycle.
- Write outputs are combinational from registered FIFO state (no input-to-output path) unless WB_BYPASS_EN.

## Configuration
- Macro WB_BYPASS_EN.
- Defined: when count == 0, ~commit_hold and push with at least one surviving slot, the filtered pair is driven directly onto the write ports in cycle N and is not enqueued (0-cycle latency, pend_mask never set for it). Input-to-output combinational path exists.
- Undefined: behaviour exactly as Operation; latency always >= 1 cycle.

## Test plan
- Reset: hold reset 2 cycles with in_vld high -> wr_n_alp = wr_n_bta = 1, count = 0, pend_mask = 0, in_ready = 1 after release.
- Single pair: push alp (r3, 0x11), bta (r7, 0x22) at N -> cycle N+1 wr_n_alp=0, wr_addr_alp=3, data 0x11; wr_n_bta=0, addr 7, data 0x22; pend_mask = 0x88 in N+1 only (undefined macro); with WB_BYPASS_EN writes appear in N.
- Hazards: push alp (r5, 0xA), bta (r5, 0xB) -> only bta writes r5=0xB, wr_n_alp=1; push alp (r0, 0x1) only -> accepted, count stays 0, no write.
- Full/hold: commit_hold=1, push 4 pairs -> count=4, in_ready=0, 5th pair held by source; release hold -> 4 commits in order on consecutive cycles, in_ready returns 1 the cycle after first pop.
- Wrap-around: stream 10 pairs back-to-back with hold toggling every 3 cycles -> all 10 pairs committed in push order, no loss or duplication, count returns to 0.
- Reset mid-operation: queue 3 pairs under hold, assert reset -> no writes issued, count=0, pend_mask=0 the following cycle.
